// File: rtl/dual_port_sram_arbiter.sv
// Arbiter sharing one single-port SRAM between fetch (I) and memory-stage (D) requesters.
// D wins conflicts unless I has been denied STARVE_LIMIT cycles in a row; read data is routed back one cycle later.
module dual_port_sram_arbiter #(
  parameter int STARVE_LIMIT = 4,
  parameter int CNT_WD       = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_req,
  input  logic [31:0]       i_addr,
  input  logic              i_flush,
  output logic              i_gnt,
  output logic              i_rvalid,
  output logic [31:0]       i_rdata,
  input  logic              d_req,
  input  logic [3:0]        d_we,
  input  logic [31:0]       d_addr,
  input  logic [31:0]       d_wdata,
  input  logic              d_flush,
  output logic              d_gnt,
  output logic              d_rvalid,
  output logic [31:0]       d_rdata,
  output logic              sram_en,
  output logic [3:0]        sram_we,
  output logic [31:0]       sram_addr,
  output logic [31:0]       sram_wdata,
  input  logic [31:0]       sram_rdata,
  output logic [CNT_WD-1:0] conflict_cnt
);

  localparam logic [3:0] STARVE_MAX = 4'(STARVE_LIMIT);

  logic [3:0]        starve_cnt_q, starve_cnt_d;
  logic              resp_valid_q, resp_valid_d;
  logic              resp_owner_q, resp_owner_d;
  logic [CNT_WD-1:0] conflict_cnt_q, conflict_cnt_d;
  logic              i_win;
  logic              d_read;

  // Grants are forced low while reset is held so every output reads zero.
  always_comb begin
    i_win = i_req & (~d_req | (starve_cnt_q == STARVE_MAX));
    i_gnt = i_win & ~reset;
    d_gnt = d_req & ~i_win & ~reset;
    d_read = d_gnt & (d_we == 4'b0000);
  end

  always_comb begin
    sram_en    = i_gnt | d_gnt;
    sram_we    = 4'b0000;
    sram_addr  = 32'h0;
    sram_wdata = 32'h0;
    if (d_gnt) begin
      sram_we    = d_we;
      sram_addr  = d_addr;
      sram_wdata = d_wdata;
    end else if (i_gnt) begin
      sram_addr  = i_addr;
    end
  end

  always_comb begin
    starve_cnt_d = 4'd0;
    if (i_req & ~i_gnt) begin
      starve_cnt_d = (starve_cnt_q == STARVE_MAX) ? starve_cnt_q : starve_cnt_q + 4'd1;
    end
    resp_valid_d = i_gnt | d_read;
    resp_owner_d = d_gnt;
    conflict_cnt_d = conflict_cnt_q;
    if (i_req & d_req & (conflict_cnt_q != {CNT_WD{1'b1}})) begin
      conflict_cnt_d = conflict_cnt_q + CNT_WD'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      starve_cnt_q   <= 4'd0;
      resp_valid_q   <= 1'b0;
      resp_owner_q   <= 1'b0;
      conflict_cnt_q <= '0;
    end else begin
      starve_cnt_q   <= starve_cnt_d;
      resp_valid_q   <= resp_valid_d;
      resp_owner_q   <= resp_owner_d;
      conflict_cnt_q <= conflict_cnt_d;
    end
  end

  // Flush only masks the response landing this cycle; the grant path is untouched.
  always_comb begin
    i_rvalid     = resp_valid_q & ~resp_owner_q & ~i_flush;
    d_rvalid     = resp_valid_q & resp_owner_q & ~d_flush;
    i_rdata      = i_rvalid ? sram_rdata : 32'h0;
    d_rdata      = d_rvalid ? sram_rdata : 32'h0;
    conflict_cnt = conflict_cnt_q;
  end

endmodule

// File: tb/tb_dual_port_sram_arbiter.sv
// Bench for dual_port_sram_arbiter: directed scenarios followed by random traffic,
// with read responses checked by a queue-based scoreboard against a reference memory.
module tb_dual_port_sram_arbiter;

  localparam int STARVE_LIMIT = 4;
  localparam int CNT_WD       = 4;
  localparam int CNT_MAX      = (1 << CNT_WD) - 1;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              i_req = 1'b0, i_flush = 1'b0;
  logic [31:0]       i_addr = 32'h0;
  logic              i_gnt, i_rvalid;
  logic [31:0]       i_rdata;
  logic              d_req = 1'b0, d_flush = 1'b0;
  logic [3:0]        d_we = 4'h0;
  logic [31:0]       d_addr = 32'h0, d_wdata = 32'h0;
  logic              d_gnt, d_rvalid;
  logic [31:0]       d_rdata;
  logic              sram_en;
  logic [3:0]        sram_we;
  logic [31:0]       sram_addr, sram_wdata;
  logic [31:0]       sram_rdata = 32'h0;
  logic [CNT_WD-1:0] conflict_cnt;

  dual_port_sram_arbiter #(.STARVE_LIMIT(STARVE_LIMIT), .CNT_WD(CNT_WD)) dut (
    .clk(clk), .reset(reset),
    .i_req(i_req), .i_addr(i_addr), .i_flush(i_flush), .i_gnt(i_gnt),
    .i_rvalid(i_rvalid), .i_rdata(i_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_flush(d_flush),
    .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .sram_en(sram_en), .sram_we(sram_we), .sram_addr(sram_addr), .sram_wdata(sram_wdata),
    .sram_rdata(sram_rdata), .conflict_cnt(conflict_cnt)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // SRAM macro stand-in: 16 words, garbage on the data bus whenever no read was issued.
  logic [31:0] sram_mem [16];
  always @(posedge clk) begin
    if (sram_en && sram_we == 4'h0) sram_rdata <= sram_mem[sram_addr[5:2]];
    else sram_rdata <= $urandom;
    if (sram_en) begin
      for (int b = 0; b < 4; b++)
        if (sram_we[b]) sram_mem[sram_addr[5:2]][8*b +: 8] <= sram_wdata[8*b +: 8];
    end
  end

  // Reference model state.
  logic [31:0] ref_mem [16];
  int          denied_m = 0;
  int          conf_m = 0;
  bit          pend_v = 0;
  bit          pend_d = 0;
  logic [31:0] pend_data = 32'h0;

  typedef struct {
    logic [31:0] data;
    int          cyc;
  } exp_t;
  exp_t i_q[$];
  exp_t d_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_i_gnt"}, 32'(i_gnt), 0);
    chk({tag, "_d_gnt"}, 32'(d_gnt), 0);
    chk({tag, "_i_rvalid"}, 32'(i_rvalid), 0);
    chk({tag, "_d_rvalid"}, 32'(d_rvalid), 0);
    chk({tag, "_i_rdata"}, i_rdata, 0);
    chk({tag, "_d_rdata"}, d_rdata, 0);
    chk({tag, "_sram_en"}, 32'(sram_en), 0);
    chk({tag, "_sram_we"}, 32'(sram_we), 0);
    chk({tag, "_sram_addr"}, sram_addr, 0);
    chk({tag, "_sram_wdata"}, sram_wdata, 0);
    chk({tag, "_conflict_cnt"}, 32'(conflict_cnt), 0);
  endtask

  // Scoreboard monitor: pops one expected response each time the DUT presents rvalid.
  always @(negedge clk) begin
    if (!reset) begin
      if (i_rvalid) begin
        if (i_q.size() == 0) chk("i_rvalid_unexpected", 32'(i_rvalid), 0);
        else begin
          chk("i_rdata", i_rdata, i_q[0].data);
          chk("i_rvalid_cycle", 32'(cyc), 32'(i_q[0].cyc));
          void'(i_q.pop_front());
        end
      end else begin
        chk("i_rdata_idle", i_rdata, 0);
        if (i_q.size() > 0 && i_q[0].cyc <= cyc) begin
          chk("i_rvalid_missing", 32'(i_rvalid), 1);
          void'(i_q.pop_front());
        end
      end
      if (d_rvalid) begin
        if (d_q.size() == 0) chk("d_rvalid_unexpected", 32'(d_rvalid), 0);
        else begin
          chk("d_rdata", d_rdata, d_q[0].data);
          chk("d_rvalid_cycle", 32'(cyc), 32'(d_q[0].cyc));
          void'(d_q.pop_front());
        end
      end else begin
        chk("d_rdata_idle", d_rdata, 0);
        if (d_q.size() > 0 && d_q[0].cyc <= cyc) begin
          chk("d_rvalid_missing", 32'(d_rvalid), 1);
          void'(d_q.pop_front());
        end
      end
    end
  end

  // One clock cycle of stimulus; predicts grants, SRAM drive and the response due next cycle.
  task automatic step(input bit ir, input logic [31:0] ia, input bit ifl,
                      input bit dr, input logic [3:0] dwe, input logic [31:0] da,
                      input logic [31:0] dwd, input bit dfl, output bit gi);
    bit eig, edg;
    logic [31:0] e_addr, e_wdata;
    logic [3:0]  e_we;
    int idx;
    @(posedge clk); #1;
    i_req = ir; i_addr = ia; i_flush = ifl;
    d_req = dr; d_we = dwe; d_addr = da; d_wdata = dwd; d_flush = dfl;
    eig = ir && (!dr || denied_m >= STARVE_LIMIT);
    edg = dr && !eig;
    if (pend_v) begin
      if (pend_d && !dfl) d_q.push_back('{pend_data, cyc});
      if (!pend_d && !ifl) i_q.push_back('{pend_data, cyc});
    end
    e_addr = edg ? da : (eig ? ia : 32'h0);
    e_we = edg ? dwe : 4'h0;
    e_wdata = edg ? dwd : 32'h0;
    @(negedge clk);
    gi = i_gnt;
    chk("i_gnt", 32'(i_gnt), 32'(eig));
    chk("d_gnt", 32'(d_gnt), 32'(edg));
    chk("sram_en", 32'(sram_en), 32'(eig | edg));
    chk("sram_addr", sram_addr, e_addr);
    chk("sram_we", 32'(sram_we), 32'(e_we));
    chk("sram_wdata", sram_wdata, e_wdata);
    chk("conflict_cnt", 32'(conflict_cnt), 32'(conf_m));
    if (ir && dr && conf_m < CNT_MAX) conf_m++;
    if (ir && !eig) denied_m = (denied_m < STARVE_LIMIT) ? denied_m + 1 : denied_m;
    else denied_m = 0;
    idx = int'(e_addr[5:2]);
    pend_v = eig || (edg && dwe == 4'h0);
    pend_d = edg;
    pend_data = ref_mem[idx];
    if (edg) begin
      for (int b = 0; b < 4; b++)
        if (dwe[b]) ref_mem[idx][8*b +: 8] = dwd[8*b +: 8];
    end
  endtask

  task automatic idle();
    bit g;
    step(0, 32'h0, 0, 0, 4'h0, 32'h0, 32'h0, 0, g);
  endtask

  initial begin
    bit g;
    bit [5:0] ipat;
    logic [31:0] v;
    for (int i = 0; i < 16; i++) begin
      v = $urandom;
      sram_mem[i] = v;
      ref_mem[i] = v;
    end
    sram_mem[0] = 32'hDEADBEEF;
    ref_mem[0] = 32'hDEADBEEF;

    // Reset held with both requests up: everything must stay zero.
    i_req = 1; d_req = 1;
    #12;
    check_zero("reset");
    i_req = 0; d_req = 0;
    @(negedge clk); reset = 0;
    idle();

    // Plain data read of 0x100.
    step(0, 32'h0, 0, 1, 4'h0, 32'h100, 32'h0, 0, g);
    idle();

    // Six-cycle conflict: I wins only once the starvation guard trips.
    ipat = '0;
    for (int k = 0; k < 6; k++) begin
      step(1, 32'h10 + 32'(4*k), 0, 1, 4'h0, 32'h20 + 32'(4*k), 32'h0, 0, g);
      ipat[k] = g;
    end
    chk("starve_pattern", 32'(ipat), 32'b010000);
    idle();
    chk("conflict_after_six", 32'(conflict_cnt), 6);

    // Partial write: no response may follow.
    step(0, 32'h0, 0, 1, 4'b0011, 32'h200, 32'h1234, 0, g);
    idle();

    // Flushed fetch response; the concurrent fetch is still granted and answered.
    step(1, 32'h8, 0, 0, 4'h0, 32'h0, 32'h0, 0, g);
    step(1, 32'hC, 1, 0, 4'h0, 32'h0, 32'h0, 0, g);
    chk("flush_i_rvalid", 32'(i_rvalid), 0);
    chk("flush_i_rdata", i_rdata, 0);
    chk("flush_regrant", 32'(g), 1);
    idle();

    // Read in flight, then reset pulsed mid-cycle: the response must vanish.
    step(0, 32'h0, 0, 1, 4'h0, 32'h4, 32'h0, 0, g);
    @(posedge clk); #3;
    chk("pre_reset_d_rvalid", 32'(d_rvalid), 1);
    d_req = 0;
    reset = 1;
    i_req = 1; d_req = 1;
    #1;
    check_zero("async_reset");
    pend_v = 0; denied_m = 0; conf_m = 0;
    @(posedge clk); #1;
    check_zero("reset_hold");
    i_req = 0; d_req = 0;
    #1 reset = 0;
    idle();
    idle();

    // Counter saturation.
    for (int k = 0; k < CNT_MAX + 5; k++)
      step(1, 32'h0, 0, 1, 4'h0, 32'h4, 32'h0, 0, g);
    idle();
    chk("conflict_saturated", 32'(conflict_cnt), CNT_MAX);

    // Random traffic.
    for (int k = 0; k < 3000; k++) begin
      bit ir, dr, ifl, dfl;
      logic [3:0] we;
      ir = ($urandom_range(0, 3) != 0);
      dr = ($urandom_range(0, 3) != 0);
      ifl = ($urandom_range(0, 5) == 0);
      dfl = ($urandom_range(0, 5) == 0);
      we = ($urandom_range(0, 2) == 0) ? 4'($urandom_range(1, 15)) : 4'h0;
      step(ir, {26'($urandom), 4'($urandom), 2'b00}, ifl,
           dr, we, {26'($urandom), 4'($urandom), 2'b00}, $urandom, dfl, g);
      if (k == 1500) begin
        @(negedge clk);
      end
    end
    idle();
    idle();
    idle();
    chk("i_queue_drained", 32'(i_q.size()), 0);
    chk("d_queue_drained", 32'(d_q.size()), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
